iic_ctrl_module: RTL and testbench
==================================

# iic_ctrl_module

Command sequencer that sits directly upstream of the IIC byte-transfer core (24C02-class EEPROM at device address 0b1010000). Accepts single-byte read/write commands from a host over a valid/ready handshake and drives the core's `Start_Sig`/`Addr_Sig`/`WrData`. It waits for the core's `Done_Sig`, returns read data and status on a one-cycle response strobe, and enforces the EEPROM write-cycle time. It detects hung transfers (the core retries forever on NACK) with a timeout and recovers by pulsing the core's reset.

## Interface
- `TIMEOUT`, 24'd1_000_000: max cycles from `Start_Sig` assertion to `Done_Sig` before abort; must be ≥1 and < 2^24.
- `TWR_CYCLES`, 24'd250_000: post-write busy time in cycles (5 ms at 50 MHz); 0 allowed.
- `RST_PULSE`, 3'd4: cycles `Core_RSTn` is held low on abort; must be ≥1.

Ports:
- `CLK` in 1: single clock; all logic on its rising edge.
- `RSTn` in 1: reset, asynchronous, active-low.
- `Cmd_Valid` in 1: host command present.
- `Cmd_Ready` out 1: block can accept a command.
- `Cmd_Rw` in 1: 0 = write, 1 = read.
- `Cmd_Addr` in 8: EEPROM word address.
- `Cmd_Data` in 8: write data; ignored for reads.
- `Rsp_Valid` out 1: one-cycle response strobe.
- `Rsp_Data` out 8: read data (0x00 for writes and errors).
- `Rsp_Err` out 1: transfer timed out; qualified by `Rsp_Valid`.
- `Start_Sig` out 2: to core; bit0 = write, bit1 = read; at most one bit set.
- `Addr_Sig` out 8: to core.
- `WrData` out 8: to core.
- `RdData` in 8: from core.
- `Done_Sig` in 1: from core; one-cycle pulse at transfer end.
- `Core_RSTn` out 1: core reset, active-low.

## Operation
- Reset values: `Cmd_Ready`=0 while `RSTn` low, then 1. `Rsp_Valid`=0, `Rsp_Data`=0x00, `Rsp_Err`=0, `Start_Sig`=2'b00, `Addr_Sig`=0x00, `WrData`=0x00. Internal counter = 0, state = IDLE.
- `Core_RSTn` = `RSTn` AND internal pulse register (register resets to 1), so the core is reset whenever this block is.
- States:
  - IDLE: `Cmd_Ready`=1. On `Cmd_Valid`&&`Cmd_Ready`: latch `Cmd_Addr`→`Addr_Sig`, `Cmd_Data`→`WrData` (0x00 if read), remember `Cmd_Rw`. Set `Start_Sig` to 2'b01 (write) or 2'b10 (read), clear the counter, go to ISSUE.
  - ISSUE: `Start_Sig` held constant; counter increments each cycle.
    - On `Done_Sig`=1: `Start_Sig`<=00. Capture `RdData` into `Rsp_Data` for reads, 0x00 for writes. `Rsp_Err`<=0, `Rsp_Valid`<=1. Go to WRWAIT (write with `TWR_CYCLES`>0) or IDLE.
    - Else if counter == `TIMEOUT`-1: `Start_Sig`<=00, pulse register<=0, counter cleared, go to ABORT.
    - If `Done_Sig` and timeout fall on the same cycle, `Done_Sig` wins.
  - WRWAIT: `Cmd_Ready`=0; counter counts 0..`TWR_CYCLES`-1, then go to IDLE.
  - ABORT: `Core_RSTn` low for `RST_PULSE` cycles, then released. Next cycle: `Rsp_Valid`=1, `Rsp_Err`=1, `Rsp_Data`=0x00, go to IDLE. No write-wait after abort.
- `Cmd_Ready` is 0 in every state except IDLE. `Cmd_Valid` outside IDLE is ignored; there is no queueing.
- `Done_Sig` seen outside ISSUE is ignored.
- `Rsp_Data`/`Rsp_Err` hold their values until the next response. There is no response backpressure; the host must sample on `Rsp_Valid`.
- `Addr_Sig`/`WrData` are stable from issue until the next accepted command.
- Counter is 24-bit unsigned and shared by ISSUE/WRWAIT/ABORT. It is cleared on each state entry and never wraps within legal parameter ranges.

## Timing
- Accept edge N (`Cmd_Valid`&&`Cmd_Ready` high in cycle N) → `Start_Sig` nonzero from cycle N+1; `Cmd_Ready` low from N+1.
- `Done_Sig` high in cycle D → `Start_Sig`=00 and `Rsp_Valid`=1 in cycle D+1. `Rsp_Valid` is low again at D+2.
- Read response: `Rsp_Data` equals `RdData` sampled in cycle D.
- Write: `Cmd_Ready` returns high at cycle D+1+`TWR_CYCLES` (D+1 when `TWR_CYCLES`=0).
- Timeout: `Start_Sig` asserted at cycle S, no `Done_Sig` → `Start_Sig`=00 and `Core_RSTn`=0 at cycle S+`TIMEOUT`. `Core_RSTn` is low for `RST_PULSE` cycles. Error `Rsp_Valid` follows one cycle after release; `Cmd_Ready`=1 the cycle after that.
- Back-to-back reads: next accept possible at D+1, giving a new `Start_Sig` at D+2.
- `RSTn` low mid-transfer: all outputs go to reset values immediately (asynchronous), `Core_RSTn`=0. No response is generated.

## Test plan
- Write 0x5A to addr 0x10 (`TWR_CYCLES`=20): `Start_Sig`=01, `Addr_Sig`=0x10, `WrData`=0x5A. Model pulses `Done_Sig` → `Rsp_Valid` with `Rsp_Err`=0, `Rsp_Data`=0x00; `Cmd_Ready` low exactly 20 cycles after the response.
- Read addr 0x10 with model `RdData`=0xA5: `Start_Sig`=10 → `Rsp_Data`=0xA5, `Rsp_Err`=0, one-cycle `Rsp_Valid`. Second read accepted the cycle after the response.
- NACK hang (`TIMEOUT`=100, model never returns `Done_Sig`): `Start_Sig` drops 100 cycles after issue, `Core_RSTn` low 4 cycles, then `Rsp_Err`=1 with `Rsp_Data`=0x00, then `Cmd_Ready`=1.
- `Done_Sig` on the exact timeout cycle: normal response, `Rsp_Err`=0, `Core_RSTn` stays 1.
- `Cmd_Valid` held high through ISSUE and WRWAIT with changing `Cmd_Addr`: only one accept per IDLE visit; `Addr_Sig` unchanged during the transfer; stray `Done_Sig` in IDLE produces no response.
- `RSTn` asserted mid-ISSUE: `Start_Sig`=00, `Core_RSTn`=0, `Rsp_Valid`=0 immediately. After release, `Cmd_Ready`=1 and a fresh write completes normally.

Source files
------------

// File: rtl/iic_ctrl_module.sv
// Host-command sequencer for an IIC EEPROM byte core: one command in flight, response strobe one cycle after Done_Sig.
// Cmd_Ready only in IDLE (no queueing); responses have no backpressure; hung transfers time out and pulse the core reset.
module iic_ctrl_module #(
  parameter logic [23:0] TIMEOUT    = 24'd1_000_000,
  parameter logic [23:0] TWR_CYCLES = 24'd250_000,
  parameter logic [2:0]  RST_PULSE  = 3'd4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic       Cmd_Rw,
  input  logic [7:0] Cmd_Addr,
  input  logic [7:0] Cmd_Data,
  output logic       Rsp_Valid,
  output logic [7:0] Rsp_Data,
  output logic       Rsp_Err,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig,
  output logic       Core_RSTn
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WRWAIT = 2'd2,
    ABORT  = 2'd3
  } state_t;

  localparam logic [23:0] RST_PULSE_W = {21'd0, RST_PULSE};

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  start_q, start_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [7:0]  rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rdy_q, rdy_d;
  logic        pulse_q, pulse_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    start_d   = start_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rsp_vld_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    pulse_d   = pulse_q;

    case (state_q)
      IDLE: begin
        if (Cmd_Valid && rdy_q) begin
          addr_d  = Cmd_Addr;
          wdat_d  = Cmd_Rw ? 8'h00 : Cmd_Data;
          rw_d    = Cmd_Rw;
          start_d = Cmd_Rw ? 2'b10 : 2'b01;
          cnt_d   = 24'd0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + 24'd1;
        // Done_Sig takes priority over a timeout landing on the same cycle.
        if (Done_Sig) begin
          start_d   = 2'b00;
          rsp_dat_d = rw_q ? RdData : 8'h00;
          rsp_err_d = 1'b0;
          rsp_vld_d = 1'b1;
          cnt_d     = 24'd0;
          state_d   = (!rw_q && (TWR_CYCLES != 24'd0)) ? WRWAIT : IDLE;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          start_d = 2'b00;
          pulse_d = 1'b0;
          cnt_d   = 24'd0;
          state_d = ABORT;
        end
      end

      WRWAIT: begin
        if (cnt_q == TWR_CYCLES - 24'd1) begin
          cnt_d   = 24'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      ABORT: begin
        // Core reset held for RST_PULSE cycles, error response the cycle
        // after release, then one more cycle before accepting again.
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == RST_PULSE_W - 24'd1) begin
          pulse_d = 1'b1;
        end
        if (cnt_q == RST_PULSE_W) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = 8'h00;
        end
        if (cnt_q == RST_PULSE_W + 24'd1) begin
          cnt_d   = 24'd0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= 24'd0;
      rw_q      <= 1'b0;
      start_q   <= 2'b00;
      addr_q    <= 8'h00;
      wdat_q    <= 8'h00;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 8'h00;
      rsp_err_q <= 1'b0;
      rdy_q     <= 1'b0;
      pulse_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rdy_q     <= rdy_d;
      pulse_q   <= pulse_d;
    end
  end

  assign Cmd_Ready = rdy_q;
  assign Rsp_Valid = rsp_vld_q;
  assign Rsp_Data  = rsp_dat_q;
  assign Rsp_Err   = rsp_err_q;
  assign Start_Sig = start_q;
  assign Addr_Sig  = addr_q;
  assign WrData    = wdat_q;
  assign Core_RSTn = RSTn & pulse_q;

endmodule

// File: tb/tb_iic_ctrl_module.sv
// Bench for iic_ctrl_module: scenario tasks drive a simple core model; responses are scored against a queue.
module tb_iic_ctrl_module;

  logic       clk = 1'b0;
  logic       RSTn = 1'b1;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic       Cmd_Rw = 1'b0;
  logic [7:0] Cmd_Addr = 8'h00;
  logic [7:0] Cmd_Data = 8'h00;
  logic       Rsp_Valid;
  logic [7:0] Rsp_Data;
  logic       Rsp_Err;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig;
  logic [7:0] WrData;
  logic [7:0] RdData = 8'h00;
  logic       Done_Sig = 1'b0;
  logic       Core_RSTn;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];
  logic       prev_vld = 1'b0;

  always #5 clk = ~clk;

  iic_ctrl_module #(
    .TIMEOUT   (24'd100),
    .TWR_CYCLES(24'd20),
    .RST_PULSE (3'd4)
  ) dut (
    .CLK      (clk),
    .RSTn     (RSTn),
    .Cmd_Valid(Cmd_Valid),
    .Cmd_Ready(Cmd_Ready),
    .Cmd_Rw   (Cmd_Rw),
    .Cmd_Addr (Cmd_Addr),
    .Cmd_Data (Cmd_Data),
    .Rsp_Valid(Rsp_Valid),
    .Rsp_Data (Rsp_Data),
    .Rsp_Err  (Rsp_Err),
    .Start_Sig(Start_Sig),
    .Addr_Sig (Addr_Sig),
    .WrData   (WrData),
    .RdData   (RdData),
    .Done_Sig (Done_Sig),
    .Core_RSTn(Core_RSTn)
  );

  // Advance one cycle, sample just after the edge, and score any response.
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (Rsp_Valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got err=%b data=%h, required no response", Rsp_Err, Rsp_Data);
      end else begin
        e = exp_q.pop_front();
        if ({Rsp_Err, Rsp_Data} !== e) begin
          n_fail++;
          $display("FAIL rsp_payload: got err=%b data=%h, required err=%b data=%h",
                   Rsp_Err, Rsp_Data, e[8], e[7:0]);
        end
      end
      if (prev_vld) begin
        n_fail++;
        $display("FAIL rsp_width: Rsp_Valid high 2 cycles, required 1");
      end
    end
    prev_vld = Rsp_Valid;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!Cmd_Ready && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (Cmd_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: Cmd_Ready=%b after %0d cycles, required 1", name, Cmd_Ready, n);
    end
  endtask

  // Present one command for a single accept edge; returns in the first ISSUE cycle.
  task automatic send_cmd(input logic rw, input logic [7:0] addr, input logic [7:0] data);
    wait_ready("send");
    Cmd_Valid = 1'b1;
    Cmd_Rw    = rw;
    Cmd_Addr  = addr;
    Cmd_Data  = data;
    tick();
    Cmd_Valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [7:0] rd);
    Done_Sig = 1'b1;
    RdData   = rd;
    tick();
    Done_Sig = 1'b0;
    RdData   = 8'h00;
  endtask

  task automatic test_reset();
    #2 RSTn = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({Cmd_Ready, Rsp_Valid, Rsp_Err, Start_Sig, Core_RSTn} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b err=%b start=%b crst=%b, required all 0",
               Cmd_Ready, Rsp_Valid, Rsp_Err, Start_Sig, Core_RSTn);
    end
    n_tests++;
    if ({Rsp_Data, Addr_Sig, WrData} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_data: got rdat=%h addr=%h wdat=%h, required 00", Rsp_Data, Addr_Sig, WrData);
    end
    RSTn = 1'b1;
    tick();
    n_tests++;
    if (Cmd_Ready !== 1'b1 || Core_RSTn !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b crst=%b, required 1 1", Cmd_Ready, Core_RSTn);
    end
  endtask

  task automatic test_write();
    int n = 0;
    send_cmd(1'b0, 8'h10, 8'h5A);
    n_tests++;
    if ({Start_Sig, Addr_Sig, WrData, Cmd_Ready} !== {2'b01, 8'h10, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL write_issue: got start=%b addr=%h wdat=%h rdy=%b, required 01 10 5a 0",
               Start_Sig, Addr_Sig, WrData, Cmd_Ready);
    end
    repeat (3) tick();
    exp_q.push_back({1'b0, 8'h00});
    pulse_done(8'hEE);
    n_tests++;
    if (Rsp_Valid !== 1'b1 || Start_Sig !== 2'b00) begin
      n_fail++;
      $display("FAIL write_done: got vld=%b start=%b, required 1 00", Rsp_Valid, Start_Sig);
    end
    while (!Cmd_Ready && n < 100) begin
      n++;
      tick();
    end
    n_tests++;
    if (n != 20) begin
      n_fail++;
      $display("FAIL write_twr: Cmd_Ready low %0d cycles after response, required 20", n);
    end
  endtask

  task automatic test_read();
    send_cmd(1'b1, 8'h10, 8'hFF);
    n_tests++;
    if ({Start_Sig, Addr_Sig, WrData} !== {2'b10, 8'h10, 8'h00}) begin
      n_fail++;
      $display("FAIL read_issue: got start=%b addr=%h wdat=%h, required 10 10 00", Start_Sig, Addr_Sig, WrData);
    end
    repeat (2) tick();
    exp_q.push_back({1'b0, 8'hA5});
    pulse_done(8'hA5);
    n_tests++;
    if (Rsp_Valid !== 1'b1 || Cmd_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_done: got vld=%b rdy=%b, required 1 1", Rsp_Valid, Cmd_Ready);
    end
    Cmd_Valid = 1'b1;
    Cmd_Rw    = 1'b1;
    Cmd_Addr  = 8'h11;
    tick();
    Cmd_Valid = 1'b0;
    n_tests++;
    if ({Start_Sig, Addr_Sig, Rsp_Valid} !== {2'b10, 8'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL read_b2b: got start=%b addr=%h vld=%b, required 10 11 0", Start_Sig, Addr_Sig, Rsp_Valid);
    end
    exp_q.push_back({1'b0, 8'h3C});
    pulse_done(8'h3C);
    n_tests++;
    if (Rsp_Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_b2b_rsp: got vld=%b, required 1", Rsp_Valid);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int m = 0;
    send_cmd(1'b0, 8'h42, 8'h99);
    exp_q.push_back({1'b1, 8'h00});
    while (Start_Sig != 2'b00 && n < 200) begin
      n++;
      tick();
    end
    n_tests++;
    if (n != 100 || Core_RSTn !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: start held %0d cycles crst=%b, required 100 0", n, Core_RSTn);
    end
    while (!Core_RSTn && m < 20) begin
      m++;
      tick();
    end
    n_tests++;
    if (m != 4) begin
      n_fail++;
      $display("FAIL timeout_pulse: Core_RSTn low %0d cycles, required 4", m);
    end
    n_tests++;
    if (Rsp_Valid !== 1'b0 || Cmd_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_release: got vld=%b rdy=%b, required 0 0", Rsp_Valid, Cmd_Ready);
    end
    tick();
    n_tests++;
    if (Rsp_Valid !== 1'b1 || Cmd_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rsp: got vld=%b rdy=%b, required 1 0", Rsp_Valid, Cmd_Ready);
    end
    tick();
    n_tests++;
    if (Cmd_Ready !== 1'b1 || Rsp_Err !== 1'b1 || Rsp_Data !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_idle: got rdy=%b err=%b data=%h, required 1 1 00", Cmd_Ready, Rsp_Err, Rsp_Data);
    end
  endtask

  task automatic test_done_at_timeout();
    send_cmd(1'b1, 8'h05, 8'h00);
    repeat (99) tick();
    exp_q.push_back({1'b0, 8'h77});
    pulse_done(8'h77);
    n_tests++;
    if ({Rsp_Valid, Start_Sig, Core_RSTn} !== 4'b1001) begin
      n_fail++;
      $display("FAIL edge_done: got vld=%b start=%b crst=%b, required 1 00 1", Rsp_Valid, Start_Sig, Core_RSTn);
    end
    repeat (5) tick();
    n_tests++;
    if (Core_RSTn !== 1'b1 || Cmd_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_after: got crst=%b rdy=%b, required 1 1", Core_RSTn, Cmd_Ready);
    end
  endtask

  task automatic test_hold_valid();
    int bad = 0;
    wait_ready("hold");
    Cmd_Valid = 1'b1;
    Cmd_Rw    = 1'b0;
    Cmd_Addr  = 8'h20;
    Cmd_Data  = 8'h11;
    tick();
    for (int i = 0; i < 5; i++) begin
      Cmd_Addr = 8'h80 + 8'(i);
      if (Start_Sig !== 2'b01 || Addr_Sig !== 8'h20) bad++;
      tick();
    end
    exp_q.push_back({1'b0, 8'h00});
    pulse_done(8'h00);
    for (int i = 0; i < 20; i++) begin
      if (Start_Sig !== 2'b00 || Addr_Sig !== 8'h20 || Cmd_Ready !== 1'b0) bad++;
      Cmd_Addr = 8'hC0 + 8'(i);
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d cycles with a re-accept or moving Addr_Sig, required 0", bad);
    end
    Cmd_Addr = 8'h30;
    tick();
    Cmd_Valid = 1'b0;
    n_tests++;
    if (Start_Sig !== 2'b01 || Addr_Sig !== 8'h30) begin
      n_fail++;
      $display("FAIL hold_reaccept: got start=%b addr=%h, required 01 30", Start_Sig, Addr_Sig);
    end
    exp_q.push_back({1'b0, 8'h00});
    pulse_done(8'h00);
    wait_ready("hold2");
    Done_Sig = 1'b1;
    tick();
    Done_Sig = 1'b0;
    tick();
    n_tests++;
    if (Rsp_Valid !== 1'b0 || Start_Sig !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_done: got vld=%b start=%b, required 0 00", Rsp_Valid, Start_Sig);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 8'h07, 8'h00);
    repeat (3) tick();
    RSTn = 1'b0;
    #1;
    n_tests++;
    if ({Start_Sig, Core_RSTn, Rsp_Valid, Cmd_Ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midrst_async: got start=%b crst=%b vld=%b rdy=%b, required 00 0 0 0",
               Start_Sig, Core_RSTn, Rsp_Valid, Cmd_Ready);
    end
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    n_tests++;
    if (Cmd_Ready !== 1'b1 || Core_RSTn !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_release: got rdy=%b crst=%b, required 1 1", Cmd_Ready, Core_RSTn);
    end
    send_cmd(1'b0, 8'h33, 8'hC3);
    n_tests++;
    if ({Start_Sig, Addr_Sig, WrData} !== {2'b01, 8'h33, 8'hC3}) begin
      n_fail++;
      $display("FAIL midrst_write: got start=%b addr=%h wdat=%h, required 01 33 c3", Start_Sig, Addr_Sig, WrData);
    end
    exp_q.push_back({1'b0, 8'h00});
    pulse_done(8'h00);
    wait_ready("midrst");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_done_at_timeout();
    test_hold_valid();
    test_reset_mid();
    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_missing: %0d expected responses never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
